// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC DRP sampler: FSM states, DRP geometry,
// code field position and the auxiliary-channel slot mapping.
package xadc_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, CAP} state_t;

  localparam logic [4:0] AUX_BASE_CH = 5'd16;
  localparam int NUM_SLOTS  = 4;
  localparam int DRP_ADDR_W = 7;
  localparam int DRP_DATA_W = 16;
  localparam int CODE_MSB   = 15;
  localparam int CODE_LSB   = 4;
  localparam int CODE_W     = CODE_MSB - CODE_LSB + 1;

  // Slots 0..3 map onto channels 16..19, an aligned block of four.
  function automatic logic is_aux(input logic [4:0] ch);
    return ch[4:2] == AUX_BASE_CH[4:2];
  endfunction

endpackage

// File: rtl/xadc_slot_avg.sv
// One boxcar-average slot: accumulates 2^AVG_LOG2 codes and emits their truncated
// mean, combinationally, in the same cycle as the final sample.
module xadc_slot_avg
  import xadc_pkg::*;
#(
  parameter int AVG_LOG2 = 4
) (
  input  logic              dclk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [CODE_W-1:0] code,
  output logic [CODE_W-1:0] avg,
  output logic              avg_valid
);

  localparam int AW = CODE_W + AVG_LOG2;

  logic [AW-1:0]       acc_reg;
  logic [AVG_LOG2-1:0] cnt_reg;
  logic [AW-1:0]       sum;

  assign sum       = acc_reg + AW'(code);
  assign avg       = sum[AW-1:AVG_LOG2];
  assign avg_valid = en && (cnt_reg == '1);

  // The counter wraps on its own; the accumulator restarts on the wrap.
  always_ff @(posedge dclk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
      acc_reg <= avg_valid ? '0 : sum;
    end
  end

endmodule

// File: rtl/xadc_drp_sampler.sv
// Reads each converted XADC channel over DRP, emits raw codes and per-slot averages
// for aux channels 16..19. Define XADC_MINMAX_EN for per-slot running min/max.
module xadc_drp_sampler
  import xadc_pkg::*;
#(
  parameter int AVG_LOG2    = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  dclk_in,
  input  logic                  reset_n_in,
  input  logic                  eoc_in,
  input  logic [4:0]            channel_in,
  output logic [DRP_ADDR_W-1:0] daddr_out,
  output logic                  den_out,
  output logic                  dwe_out,
  output logic [DRP_DATA_W-1:0] di_out,
  input  logic [DRP_DATA_W-1:0] do_in,
  input  logic                  drdy_in,
  output logic [CODE_W-1:0]     sample_out,
  output logic [4:0]            sample_ch_out,
  output logic                  sample_valid_out,
  output logic [CODE_W-1:0]     avg_out,
  output logic [1:0]            avg_slot_out,
  output logic                  avg_valid_out,
  output logic                  overrun_out,
  output logic                  timeout_out,
  input  logic                  clr_flags_in
`ifdef XADC_MINMAX_EN
  ,
  input  logic [1:0]            minmax_slot_in,
  output logic [CODE_W-1:0]     min_out,
  output logic [CODE_W-1:0]     max_out
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TERM = TW'(TIMEOUT_CYC - 1);

  state_t              state_reg, state_next;
  logic [4:0]          ch_reg;
  logic [TW-1:0]       timer_reg;
  logic [CODE_W-1:0]   code_reg;
  logic [4:0]          sample_ch_reg;
  logic                overrun_reg, timeout_reg;
  logic [CODE_W-1:0]   avg_hold_reg;
  logic [1:0]          avg_slot_hold_reg;
  logic                timeout_hit, overrun_hit, cap_aux;
  logic                unused_low_bits;

  assign unused_low_bits = ^do_in[CODE_LSB-1:0];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (eoc_in) state_next = REQ;
      REQ:     state_next = WAIT;
      WAIT:    if (drdy_in) state_next = CAP;
               else if (timer_reg == TERM) state_next = IDLE;
      CAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // drdy on the terminal count takes priority over the timeout.
  assign timeout_hit = (state_reg == WAIT) && !drdy_in && (timer_reg == TERM);
  assign overrun_hit = eoc_in && (state_reg != IDLE);

  // Timer is 0 while den is high, so the timeout lands TIMEOUT_CYC cycles after den.
  always_ff @(posedge dclk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_reg     <= IDLE;
      ch_reg        <= '0;
      timer_reg     <= '0;
      code_reg      <= '0;
      sample_ch_reg <= '0;
      overrun_reg   <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && eoc_in) begin
        ch_reg    <= channel_in;
        timer_reg <= '0;
      end else if (state_reg == REQ || state_reg == WAIT) begin
        timer_reg <= timer_reg + 1'b1;
      end
      if (state_reg == WAIT && drdy_in) begin
        code_reg      <= do_in[CODE_MSB:CODE_LSB];
        sample_ch_reg <= ch_reg;
      end
      if (overrun_hit)       overrun_reg <= 1'b1;
      else if (clr_flags_in) overrun_reg <= 1'b0;
      if (timeout_hit)       timeout_reg <= 1'b1;
      else if (clr_flags_in) timeout_reg <= 1'b0;
    end
  end

  assign daddr_out        = {{(DRP_ADDR_W-5){1'b0}}, ch_reg};
  assign den_out          = (state_reg == REQ);
  assign dwe_out          = 1'b0;
  assign di_out           = '0;
  assign sample_out       = code_reg;
  assign sample_ch_out    = sample_ch_reg;
  assign sample_valid_out = (state_reg == CAP);
  assign overrun_out      = overrun_reg;
  assign timeout_out      = timeout_reg;
  assign cap_aux          = (state_reg == CAP) && is_aux(ch_reg);

  logic [NUM_SLOTS-1:0] slot_en, slot_valid;
  logic [CODE_W-1:0]    slot_avg [NUM_SLOTS];
  logic [CODE_W-1:0]    avg_live;
  logic [1:0]           slot_live;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign slot_en[gi] = cap_aux && (ch_reg[1:0] == 2'(gi));
      xadc_slot_avg #(.AVG_LOG2(AVG_LOG2)) u_slot (
        .dclk      (dclk_in),
        .reset_n   (reset_n_in),
        .en        (slot_en[gi]),
        .code      (code_reg),
        .avg       (slot_avg[gi]),
        .avg_valid (slot_valid[gi])
      );
    end
  endgenerate

  always_comb begin
    avg_live  = '0;
    slot_live = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_valid[i]) begin
        avg_live  = slot_avg[i];
        slot_live = 2'(i);
      end
    end
  end

  // The finished average appears in its strobe cycle and is held afterwards.
  always_ff @(posedge dclk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      avg_hold_reg      <= '0;
      avg_slot_hold_reg <= '0;
    end else if (avg_valid_out) begin
      avg_hold_reg      <= avg_live;
      avg_slot_hold_reg <= slot_live;
    end
  end

  assign avg_valid_out = |slot_valid;
  assign avg_out       = avg_valid_out ? avg_live  : avg_hold_reg;
  assign avg_slot_out  = avg_valid_out ? slot_live : avg_slot_hold_reg;

`ifdef XADC_MINMAX_EN
  logic [CODE_W-1:0] min_all [NUM_SLOTS];
  logic [CODE_W-1:0] max_all [NUM_SLOTS];

  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_minmax
      logic [CODE_W-1:0] min_reg, max_reg;
      always_ff @(posedge dclk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
          min_reg <= '1;
          max_reg <= '0;
        end else if (clr_flags_in) begin
          min_reg <= '1;
          max_reg <= '0;
        end else if (slot_en[gi]) begin
          if (code_reg < min_reg) min_reg <= code_reg;
          if (code_reg > max_reg) max_reg <= code_reg;
        end
      end
      assign min_all[gi] = min_reg;
      assign max_all[gi] = max_reg;
    end
  endgenerate

  assign min_out = min_all[minmax_slot_in];
  assign max_out = max_all[minmax_slot_in];
`endif

endmodule

// File: tb/tb_xadc_drp_sampler.sv
// Scoreboard bench for xadc_drp_sampler: expected samples/averages are queued when
// drdy is driven and popped by a monitor on each strobe.
module tb_xadc_drp_sampler;

  localparam int AVG_LOG2    = 4;
  localparam int TIMEOUT_CYC = 64;

  logic        DCLK_TB;
  logic        RESET_TB;
  logic        eoc_in;
  logic [4:0]  channel_in;
  logic [6:0]  daddr_out;
  logic        den_out, dwe_out;
  logic [15:0] di_out, do_in;
  logic        drdy_in;
  logic [11:0] sample_out, avg_out;
  logic [4:0]  sample_ch_out;
  logic        sample_valid_out, avg_valid_out;
  logic [1:0]  avg_slot_out;
  logic        overrun_out, timeout_out, clr_flags_in;
`ifdef XADC_MINMAX_EN
  logic [1:0]  minmax_slot_in;
  logic [11:0] min_out, max_out;
`endif

  xadc_drp_sampler #(.AVG_LOG2(AVG_LOG2), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .dclk_in          (DCLK_TB),
    .reset_n_in       (RESET_TB),
    .eoc_in           (eoc_in),
    .channel_in       (channel_in),
    .daddr_out        (daddr_out),
    .den_out          (den_out),
    .dwe_out          (dwe_out),
    .di_out           (di_out),
    .do_in            (do_in),
    .drdy_in          (drdy_in),
    .sample_out       (sample_out),
    .sample_ch_out    (sample_ch_out),
    .sample_valid_out (sample_valid_out),
    .avg_out          (avg_out),
    .avg_slot_out     (avg_slot_out),
    .avg_valid_out    (avg_valid_out),
    .overrun_out      (overrun_out),
    .timeout_out      (timeout_out),
    .clr_flags_in     (clr_flags_in)
`ifdef XADC_MINMAX_EN
    ,
    .minmax_slot_in   (minmax_slot_in),
    .min_out          (min_out),
    .max_out          (max_out)
`endif
  );

  initial DCLK_TB = 1'b0;
  always #5 DCLK_TB = ~DCLK_TB;

  int errors = 0;
  int checks = 0;
  int sample_seen = 0;
  int avg_seen = 0;
  logic [16:0] sample_q[$];   // {ch, code}
  logic [13:0] avg_q[$];      // {slot, avg}
  int acc_m[4];
  int cnt_m[4];

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge DCLK_TB) begin
    if (RESET_TB === 1'b1) begin
      if (sample_valid_out === 1'b1) begin
        logic [16:0] exp_s;
        sample_seen++;
        checks++;
        if (sample_q.size() == 0) begin
          errors++;
          $display("FAIL sample_unexpected: got ch=%0d code=%h, required no strobe", sample_ch_out, sample_out);
        end else begin
          exp_s = sample_q.pop_front();
          if ({sample_ch_out, sample_out} !== exp_s) begin
            errors++;
            $display("FAIL sample_data: got ch=%0d code=%h, required ch=%0d code=%h",
                     sample_ch_out, sample_out, exp_s[16:12], exp_s[11:0]);
          end
        end
      end
      if (avg_valid_out === 1'b1) begin
        logic [13:0] exp_a;
        avg_seen++;
        checks++;
        if (avg_q.size() == 0) begin
          errors++;
          $display("FAIL avg_unexpected: got slot=%0d avg=%h, required no strobe", avg_slot_out, avg_out);
        end else begin
          exp_a = avg_q.pop_front();
          if ({avg_slot_out, avg_out} !== exp_a) begin
            errors++;
            $display("FAIL avg_data: got slot=%0d avg=%h, required slot=%0d avg=%h",
                     avg_slot_out, avg_out, exp_a[13:12], exp_a[11:0]);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut;
    @(posedge DCLK_TB); #1;
    RESET_TB = 1'b0;
    eoc_in = 1'b0; channel_in = '0; drdy_in = 1'b0; do_in = '0; clr_flags_in = 1'b0;
    repeat (10) @(posedge DCLK_TB);
    #1;
    RESET_TB = 1'b1;
    sample_q.delete();
    avg_q.delete();
    for (int i = 0; i < 4; i++) begin acc_m[i] = 0; cnt_m[i] = 0; end
  endtask

  // One DRP transaction; optionally injects an eoc (and clr) during WAIT.
  task automatic do_read(input logic [4:0] ch, input logic [15:0] data, input int lat,
                         input bit inj_eoc, input bit inj_clr);
    int s;
    eoc_in = 1'b1; channel_in = ch;
    @(posedge DCLK_TB); #1;
    eoc_in = 1'b0; channel_in = 5'd0;
    @(negedge DCLK_TB);
    checks++;
    if (den_out !== 1'b1 || daddr_out !== {2'b00, ch}) begin
      errors++;
      $display("FAIL den_start: got den=%b daddr=%h, required den=1 daddr=%h", den_out, daddr_out, {2'b00, ch});
    end
    @(negedge DCLK_TB);
    checks++;
    if (den_out !== 1'b0) begin
      errors++;
      $display("FAIL den_width: got den=%b, required 0", den_out);
    end
    @(posedge DCLK_TB); #1;
    if (inj_eoc) begin
      eoc_in = 1'b1; channel_in = 5'd3; clr_flags_in = inj_clr;
      @(posedge DCLK_TB); #1;
      eoc_in = 1'b0; channel_in = 5'd0; clr_flags_in = 1'b0;
    end
    repeat (lat) begin @(posedge DCLK_TB); #1; end
    sample_q.push_back({ch, data[15:4]});
    if (ch >= 5'd16 && ch <= 5'd19) begin
      s = int'(ch) - 16;
      acc_m[s] += int'(data[15:4]);
      cnt_m[s]++;
      if (cnt_m[s] == (1 << AVG_LOG2)) begin
        avg_q.push_back({2'(s), 12'(acc_m[s] >> AVG_LOG2)});
        acc_m[s] = 0;
        cnt_m[s] = 0;
      end
    end
    drdy_in = 1'b1; do_in = data;
    @(posedge DCLK_TB); #1;
    drdy_in = 1'b0; do_in = 16'($urandom);
    @(negedge DCLK_TB);
    checks++;
    if (sample_valid_out !== 1'b1) begin
      errors++;
      $display("FAIL cap_latency: got sample_valid=%b one cycle after drdy, required 1", sample_valid_out);
    end
    @(posedge DCLK_TB); #1;
  endtask

  task automatic pulse_clr;
    clr_flags_in = 1'b1;
    @(posedge DCLK_TB); #1;
    clr_flags_in = 1'b0;
  endtask

  task automatic test_reset;
    reset_dut();
    @(negedge DCLK_TB);
    checks++;
    if ({den_out, dwe_out, sample_valid_out, avg_valid_out, overrun_out, timeout_out} !== 6'b0 ||
        daddr_out !== 7'h00 || di_out !== 16'h0 || sample_out !== 12'h0 || sample_ch_out !== 5'h0 ||
        avg_out !== 12'h0 || avg_slot_out !== 2'h0) begin
      errors++;
      $display("FAIL reset_outputs: got den=%b daddr=%h sample=%h avg=%h ovr=%b to=%b, required all 0",
               den_out, daddr_out, sample_out, avg_out, overrun_out, timeout_out);
    end
  endtask

  task automatic test_first_read;
    repeat (3) @(posedge DCLK_TB);
    #1;
    do_read(5'd16, 16'h5550, 2, 1'b0, 1'b0);
  endtask

  task automatic test_avg_single;
    int a0 = avg_seen;
    for (int i = 0; i < 16; i++) do_read(5'd17, 16'hABC0, 1 + (i % 3), 1'b0, 1'b0);
    repeat (2) @(negedge DCLK_TB);
    checks++;
    if (avg_seen - a0 != 1 || avg_q.size() != 0) begin
      errors++;
      $display("FAIL avg_single_count: got %0d strobes (%0d pending), required 1", avg_seen - a0, avg_q.size());
    end
  endtask

  task automatic test_interleave;
    int a0;
    reset_dut();
    a0 = avg_seen;
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) do_read(5'd16, 16'h1000, 1, 1'b0, 1'b0);
      else            do_read(5'd18, 16'h3000, 2, 1'b0, 1'b0);
    end
    repeat (2) @(negedge DCLK_TB);
    checks++;
    if (avg_seen - a0 != 2 || avg_q.size() != 0 || sample_q.size() != 0) begin
      errors++;
      $display("FAIL interleave_count: got %0d avg strobes (%0d pending), required 2", avg_seen - a0, avg_q.size());
    end
  endtask

  task automatic test_truncation;
    for (int i = 0; i < 16; i++) do_read(5'd19, 16'($urandom), 1, 1'b0, 1'b0);
    repeat (2) @(negedge DCLK_TB);
    checks++;
    if (avg_q.size() != 0 || sample_q.size() != 0) begin
      errors++;
      $display("FAIL truncation_pending: got %0d avg / %0d samples unconsumed, required 0", avg_q.size(), sample_q.size());
    end
  endtask

  task automatic test_timeout;
    int k = 0;
    int s0 = sample_seen;
    eoc_in = 1'b1; channel_in = 5'd17;
    @(posedge DCLK_TB); #1;
    eoc_in = 1'b0;
    @(negedge DCLK_TB);
    checks++;
    if (den_out !== 1'b1) begin
      errors++;
      $display("FAIL timeout_den: got den=%b, required 1", den_out);
    end
    for (int i = 1; i <= TIMEOUT_CYC + 10; i++) begin
      @(negedge DCLK_TB);
      if (timeout_out === 1'b1) begin k = i; break; end
    end
    checks++;
    if (k != TIMEOUT_CYC) begin
      errors++;
      $display("FAIL timeout_delay: got %0d cycles after den (0 = never), required %0d", k, TIMEOUT_CYC);
    end
    checks++;
    if (sample_seen != s0) begin
      errors++;
      $display("FAIL timeout_nosample: got %0d strobes, required 0", sample_seen - s0);
    end
    @(posedge DCLK_TB); #1;
    do_read(5'd17, 16'h1230, 3, 1'b0, 1'b0);
    checks++;
    if (timeout_out !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b, required 1", timeout_out);
    end
    pulse_clr();
    @(negedge DCLK_TB);
    checks++;
    if (timeout_out !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %b, required 0", timeout_out);
    end
  endtask

  task automatic test_overrun;
    do_read(5'd18, 16'h4440, 3, 1'b1, 1'b0);
    checks++;
    if (overrun_out !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b, required 1", overrun_out);
    end
    pulse_clr();
    @(negedge DCLK_TB);
    checks++;
    if (overrun_out !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %b, required 0", overrun_out);
    end
    @(posedge DCLK_TB); #1;
    do_read(5'd18, 16'h5550, 2, 1'b1, 1'b1);
    checks++;
    if (overrun_out !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set_wins: got %b, required 1", overrun_out);
    end
    pulse_clr();
    @(negedge DCLK_TB);
    checks++;
    if (overrun_out !== 1'b0 || sample_q.size() != 0) begin
      errors++;
      $display("FAIL overrun_final: got ovr=%b pending=%0d, required ovr=0 pending=0", overrun_out, sample_q.size());
    end
  endtask

  task automatic test_reset_mid_read;
    int s0 = sample_seen;
    @(posedge DCLK_TB); #1;
    eoc_in = 1'b1; channel_in = 5'd16;
    @(posedge DCLK_TB); #1;
    eoc_in = 1'b0;
    @(posedge DCLK_TB); #1;
    RESET_TB = 1'b0;
    #2;
    checks++;
    if (den_out !== 1'b0 || daddr_out !== 7'h00) begin
      errors++;
      $display("FAIL reset_async: got den=%b daddr=%h, required 0/00", den_out, daddr_out);
    end
    @(posedge DCLK_TB); #1;
    RESET_TB = 1'b1;
    for (int i = 0; i < 4; i++) begin acc_m[i] = 0; cnt_m[i] = 0; end
    drdy_in = 1'b1; do_in = 16'h7770;
    @(posedge DCLK_TB); #1;
    drdy_in = 1'b0;
    repeat (3) @(negedge DCLK_TB);
    checks++;
    if (sample_seen != s0) begin
      errors++;
      $display("FAIL late_drdy: got %0d strobes, required 0", sample_seen - s0);
    end
  endtask

`ifdef XADC_MINMAX_EN
  task automatic test_minmax;
    reset_dut();
    minmax_slot_in = 2'd3;
    do_read(5'd19, 16'h2000, 1, 1'b0, 1'b0);
    do_read(5'd19, 16'h0500, 1, 1'b0, 1'b0);
    do_read(5'd19, 16'h7FF0, 1, 1'b0, 1'b0);
    @(negedge DCLK_TB);
    checks++;
    if (min_out !== 12'h050 || max_out !== 12'h7FF) begin
      errors++;
      $display("FAIL minmax: got min=%h max=%h, required min=050 max=7ff", min_out, max_out);
    end
  endtask
`endif

  initial begin
    RESET_TB = 1'b0;
    eoc_in = 1'b0; channel_in = '0; drdy_in = 1'b0; do_in = '0; clr_flags_in = 1'b0;
`ifdef XADC_MINMAX_EN
    minmax_slot_in = 2'd0;
`endif
    test_reset();
    test_first_read();
    test_avg_single();
    test_interleave();
    test_truncation();
    test_timeout();
    test_overrun();
    test_reset_mid_read();
`ifdef XADC_MINMAX_EN
    test_minmax();
`endif
    repeat (3) @(negedge DCLK_TB);
    checks++;
    if (sample_q.size() != 0 || avg_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d samples / %0d avgs pending, required 0", sample_q.size(), avg_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xadc_drp_sampler.md
Name: xadc_drp_sampler

Overview:
- Sits directly downstream of the xadc wrapper.
- On each end-of-conversion it issues a DRP read of the converted channel's status register, waits for the read to complete, and extracts the 12-bit code from do[15:4].
- Emits every raw sample with its channel tag.
- Keeps a per-slot boxcar average of 2^AVG_LOG2 samples for auxiliary channels 16..19 (the tracker's light sensors).

Parameters:
- AVG_LOG2, 4: log2 of the number of samples per average (legal range 1..6).
- TIMEOUT_CYC, 64: DRP read timeout, in dclk_in cycles, counted from den_out.

Ports:
- dclk_in  input  1  DRP clock; all logic is on its rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- eoc_in  input  1  end-of-conversion from xadc.
- channel_in  input  5  channel_out from xadc; valid while eoc_in is high.
- daddr_out  output  7  DRP address.
- den_out  output  1  DRP enable; one-cycle pulse.
- dwe_out  output  1  DRP write enable; always 0.
- di_out  output  16  DRP write data; always 0.
- do_in  input  16  DRP read data.
- drdy_in  input  1  DRP read data valid.
- sample_out  output  12  last raw code, do_in[15:4].
- sample_ch_out  output  5  channel of sample_out.
- sample_valid_out  output  1  one-cycle strobe when sample_out updates.
- avg_out  output  12  finished average.
- avg_slot_out  output  2  slot (channel-16) of avg_out.
- avg_valid_out  output  1  one-cycle strobe when avg_out updates.
- overrun_out  output  1  sticky flag: an eoc arrived while a read was in flight.
- timeout_out  output  1  sticky flag: a DRP read timed out.
- clr_flags_in  input  1  synchronous clear of overrun_out and timeout_out.

Behaviour:
- Reset (async, reset_n_in=0):
  - All outputs are 0; FSM goes to IDLE.
  - All accumulators and sample counters are 0.
  - daddr_out is 7'h00.
- FSM states: IDLE, REQ, WAIT, CAP.
- IDLE:
  - On eoc_in=1, latch ch = channel_in and drive daddr_out = {2'b00, ch}.
  - Next state is REQ.
- REQ:
  - den_out=1 for exactly this cycle; the timeout counter loads 0.
  - Next state is WAIT.
- WAIT:
  - If drdy_in=1, register do_in[15:4] and go to CAP.
  - Otherwise, when the counter reaches TIMEOUT_CYC-1, set timeout_out and return to IDLE; no sample is emitted.
- CAP:
  - sample_out, sample_ch_out and sample_valid_out=1 are driven in this cycle. Latency from the drdy_in cycle to sample_valid_out is 1 cycle.
  - If ch is in 16..19, slot s = ch[1:0]:
    - acc[s] += code; cnt[s]++.
    - When cnt[s] wraps (2^AVG_LOG2 samples), avg_out = (acc[s] + code) >> AVG_LOG2, avg_slot_out = s, avg_valid_out=1 in the same cycle; acc[s] and cnt[s] clear.
  - Next state is IDLE.
- Accumulator width is 12+AVG_LOG2 bits, so it cannot overflow. The shift truncates (no rounding).
- Each slot's counter is independent; interleaved channels never corrupt one another.
- eoc_in=1 in REQ, WAIT or CAP: overrun_out is set and that conversion is dropped.
  - Exception: eoc in the CAP cycle is also dropped.
- eoc_in=1 in the IDLE cycle immediately after CAP is accepted normally.
- drdy_in outside WAIT is ignored.
- drdy_in on the same cycle as the timeout terminal count: drdy wins, no timeout.
- clr_flags_in together with a new set event: set wins.
- Reset asserted mid-read: the FSM returns to IDLE immediately. A late drdy_in after release is ignored because the FSM is in IDLE.

Optional Feature:
- Macro: XADC_MINMAX_EN.
- Defined:
  - Adds ports min_out[11:0] and max_out[11:0], plus input minmax_slot_in[1:0].
  - Per-slot running min/max of raw codes, updated in CAP; minmax_slot_in selects which slot is shown.
  - Reset values are min=12'hFFF and max=12'h000. clr_flags_in also reinitialises them.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package xadc_pkg holds:
  - FSM state enum (IDLE/REQ/WAIT/CAP);
  - AUX_BASE_CH = 5'd16;
  - NUM_SLOTS = 4;
  - DRP address width 7, data width 16;
  - CODE_MSB=15, CODE_LSB=4.
- One natural sub-module, xadc_slot_avg: a single-slot accumulator, counter and average strobe, instantiated 4 times.

Test Plan:
- Reset held 10 cycles, then released:
  - all outputs 0 and daddr_out=0;
  - an eoc 3 cycles later on channel 16 → den_out pulses exactly 1 cycle, 1 cycle after eoc, with daddr_out=7'h10.
- 16 reads on channel 17, all returning do_in=16'hABC0 → 16 sample_valid_out strobes with sample_out=12'hABC; one avg_valid_out with avg_out=12'hABC and avg_slot_out=1.
- Channels 16 and 18 alternate, codes 0x100 and 0x300, 32 reads → avg 0x100 on slot 0 and 0x300 on slot 2; no cross-talk.
- drdy_in is never returned → timeout_out=1 exactly TIMEOUT_CYC cycles after den_out; no sample_valid_out; the next eoc is serviced normally.
- eoc during WAIT → overrun_out=1 and the original read completes. clr_flags_in pulse → flags return to 0. Repeat with clr and eoc in the same cycle → overrun stays 1.
- With XADC_MINMAX_EN: codes 0x200, 0x050, 0x7FF on channel 19 → min_out=0x050 and max_out=0x7FF with minmax_slot_in=3.
